// File: rtl/segre_pkg.sv
// Shared types and sizing for the history-file recovery controller.
package segre_pkg;

  localparam int unsigned HF_DEPTH   = 8;
  localparam int unsigned HF_IDX_W   = $clog2(HF_DEPTH);
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CAUSE_W    = 4;

  typedef logic [CAUSE_W-1:0] exc_cause_t;

  // One-hot so each state-decoded output is a single flop bit.
  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_WAIT_HEAD = 5'b00010,
    ST_FLUSH     = 5'b00100,
    ST_RESTORE   = 5'b01000,
    ST_DONE      = 5'b10000
  } hf_rec_state_e;

endpackage

// File: rtl/segre_hf_recovery_ctrl_if.sv
// Bundle of exception, history-file, writeback and register-file signals around the controller.
interface segre_hf_recovery_ctrl_if
  import segre_pkg::*;
;
  logic                  exc_i;
  logic [HF_IDX_W-1:0]   exc_id_i;
  exc_cause_t            exc_cause_i;
  logic [HF_IDX_W-1:0]   hf_head_i;
  logic [HF_IDX_W-1:0]   hf_tail_i;
  logic                  hf_empty_i;
  logic [HF_IDX_W-1:0]   hf_rd_idx_o;
  logic [REG_ADDR_W-1:0] hf_rd_reg_i;
  logic [WORD_W-1:0]     hf_rd_val_i;
  logic                  hf_pop_o;
  logic                  wb_req_i;
  logic [REG_ADDR_W-1:0] wb_addr_i;
  logic [WORD_W-1:0]     wb_data_i;
  logic                  wb_gnt_o;
  logic                  rf_we_o;
  logic [REG_ADDR_W-1:0] rf_waddr_o;
  logic [WORD_W-1:0]     rf_wdata_o;
  logic                  stall_o;
  logic                  flush_o;
  logic                  recovering_o;
  logic                  exc_taken_o;
  exc_cause_t            exc_cause_o;

  modport master (
    input  exc_i, exc_id_i, exc_cause_i, hf_head_i, hf_tail_i, hf_empty_i,
           hf_rd_reg_i, hf_rd_val_i, wb_req_i, wb_addr_i, wb_data_i,
    output hf_rd_idx_o, hf_pop_o, wb_gnt_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           stall_o, flush_o, recovering_o, exc_taken_o, exc_cause_o
  );

  modport slave (
    output exc_i, exc_id_i, exc_cause_i, hf_head_i, hf_tail_i, hf_empty_i,
           hf_rd_reg_i, hf_rd_val_i, wb_req_i, wb_addr_i, wb_data_i,
    input  hf_rd_idx_o, hf_pop_o, wb_gnt_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           stall_o, flush_o, recovering_o, exc_taken_o, exc_cause_o
  );

endinterface

// File: rtl/segre_hf_age_cmp.sv
// Modular age compare: a is strictly older than b when its distance from head is smaller.
module segre_hf_age_cmp
  import segre_pkg::*;
(
  input  logic [HF_IDX_W-1:0] a_i,
  input  logic [HF_IDX_W-1:0] b_i,
  input  logic [HF_IDX_W-1:0] head_i,
  output logic                a_older_o
);

  logic [HF_IDX_W-1:0] age_a;
  logic [HF_IDX_W-1:0] age_b;

  // Power-of-two depth lets the subtraction wrap modulo HF_DEPTH for free.
  assign age_a     = a_i - head_i;
  assign age_b     = b_i - head_i;
  assign a_older_o = (age_a < age_b);

endmodule

// File: rtl/segre_hf_recovery_ctrl.sv
// Precise-exception rollback sequencer: waits for the excepting entry to reach the HF head,
// flushes, then walks the HF from tail back to that entry restoring old register values.
module segre_hf_recovery_ctrl
  import segre_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rsn_i,
  segre_hf_recovery_ctrl_if.master bus
);

  hf_rec_state_e       state_q;
  logic [HF_IDX_W-1:0] exc_id_q;
  exc_cause_t          cause_q;

  logic [HF_IDX_W-1:0] rd_idx;
  logic                new_older;
  logic                port_open;
  logic                restoring;
  logic                restore_we;
  logic                wb_gnt;

  segre_hf_age_cmp u_age_cmp (
    .a_i       (bus.exc_id_i),
    .b_i       (exc_id_q),
    .head_i    (bus.hf_head_i),
    .a_older_o (new_older)
  );

  assign rd_idx = bus.hf_tail_i - HF_IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q  <= ST_IDLE;
      exc_id_q <= '0;
      cause_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.exc_i) begin
            exc_id_q <= bus.exc_id_i;
            cause_q  <= bus.exc_cause_i;
            state_q  <= ST_WAIT_HEAD;
          end
        end
        ST_WAIT_HEAD: begin
          // A captured entry at the head has age 0, so replacement and exit never collide.
          if (bus.exc_i && new_older) begin
            exc_id_q <= bus.exc_id_i;
            cause_q  <= bus.exc_cause_i;
          end
          if (bus.hf_head_i == exc_id_q) state_q <= ST_FLUSH;
        end
        ST_FLUSH:   state_q <= ST_RESTORE;
        ST_RESTORE: begin
          if (bus.hf_empty_i || (rd_idx == exc_id_q)) state_q <= ST_DONE;
        end
        ST_DONE:    state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-port arbitration: restore owns the port outside IDLE/WAIT_HEAD.
  assign port_open  = (state_q == ST_IDLE) || (state_q == ST_WAIT_HEAD);
  assign restoring  = (state_q == ST_RESTORE);
  assign restore_we = restoring && !bus.hf_empty_i && (bus.hf_rd_reg_i != '0);
  assign wb_gnt     = port_open && bus.wb_req_i;

  assign bus.hf_rd_idx_o  = rd_idx;
  assign bus.hf_pop_o     = restoring && !bus.hf_empty_i;
  assign bus.wb_gnt_o     = wb_gnt;
  assign bus.rf_we_o      = restore_we || wb_gnt;
  assign bus.rf_waddr_o   = restore_we ? bus.hf_rd_reg_i :
                            (wb_gnt ? bus.wb_addr_i : '0);
  assign bus.rf_wdata_o   = restore_we ? bus.hf_rd_val_i :
                            (wb_gnt ? bus.wb_data_i : '0);
  assign bus.stall_o      = !port_open || (state_q == ST_WAIT_HEAD);
  assign bus.flush_o      = (state_q == ST_FLUSH);
  assign bus.recovering_o = restoring;
  assign bus.exc_taken_o  = (state_q == ST_DONE);
  assign bus.exc_cause_o  = (state_q == ST_DONE) ? cause_q : '0;

  a_state_onehot: assert property (@(posedge clk_i) disable iff (rsn_i) $onehot(state_q));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rsn_i)
                                   !(bus.hf_pop_o && bus.hf_empty_i));
  a_one_source:   assert property (@(posedge clk_i) disable iff (rsn_i)
                                   bus.rf_we_o |-> (wb_gnt ^ restore_we));
  a_restore_underflow: assert property (@(posedge clk_i) disable iff (rsn_i)
                                        !(restoring && bus.hf_empty_i));

endmodule

// File: tb/tb_segre_hf_recovery_ctrl.sv
// Directed self-checking bench for segre_hf_recovery_ctrl with a small HF storage model.
module tb_segre_hf_recovery_ctrl;
  import segre_pkg::*;

  logic clk_i = 1'b0;
  logic rsn_i;

  segre_hf_recovery_ctrl_if bus ();

  segre_hf_recovery_ctrl dut (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [REG_ADDR_W-1:0] hf_reg [HF_DEPTH];
  logic [WORD_W-1:0]     hf_val [HF_DEPTH];

  assign bus.hf_rd_reg_i = hf_reg[bus.hf_rd_idx_o];
  assign bus.hf_rd_val_i = hf_val[bus.hf_rd_idx_o];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations gathered by run_recovery for the calling test to compare.
  int                    stall_cyc;
  int                    flush_cyc;
  int                    taken_cyc;
  int                    busy_gnt;
  exc_cause_t            taken_cause;
  logic [31:0]           pop_trace;
  logic [REG_ADDR_W-1:0] wr_addr [$];
  logic [WORD_W-1:0]     wr_data [$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_i       = 1'b0;
    bus.exc_id_i    = '0;
    bus.exc_cause_i = '0;
    bus.hf_empty_i  = 1'b0;
    bus.wb_req_i    = 1'b0;
    bus.wb_addr_i   = '0;
    bus.wb_data_i   = '0;
  endtask

  // Step the DUT until stall drops (bounded), popping the HF model tail as the DUT pops.
  task automatic run_recovery();
    logic p;
    stall_cyc = 0; flush_cyc = 0; taken_cyc = 0; busy_gnt = 0;
    taken_cause = '0; pop_trace = '0;
    wr_addr.delete(); wr_data.delete();
    for (int c = 0; c < 40; c++) begin
      if (!bus.stall_o) break;
      stall_cyc++;
      if (bus.flush_o) flush_cyc++;
      if (bus.exc_taken_o) begin
        taken_cyc++;
        taken_cause = bus.exc_cause_o;
      end
      if (bus.flush_o || bus.recovering_o || bus.exc_taken_o) begin
        if (bus.wb_gnt_o) busy_gnt++;
        if (bus.rf_we_o) begin
          wr_addr.push_back(bus.rf_waddr_o);
          wr_data.push_back(bus.rf_wdata_o);
        end
      end
      p = bus.hf_pop_o;
      if (p) pop_trace = {pop_trace[27:0], 1'b1, bus.hf_rd_idx_o};
      tick();
      if (p) bus.hf_tail_i = bus.hf_tail_i - HF_IDX_W'(1);
      #1;
    end
  endtask

  function automatic logic [51:0] out_vec();
    return {bus.stall_o, bus.flush_o, bus.recovering_o, bus.exc_taken_o, bus.exc_cause_o,
            bus.hf_pop_o, bus.wb_gnt_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o};
  endfunction

  task automatic test_reset();
    idle_inputs();
    bus.hf_head_i = '0;
    bus.hf_tail_i = HF_IDX_W'(1);
    rsn_i = 1'b1;
    tick(); tick();
    total_cnt++;
    if (out_vec() !== 52'd0) $display("FAIL reset_outputs: got %h want 0", out_vec());
    else pass_cnt++;
    total_cnt++;
    if (bus.hf_rd_idx_o !== 3'd0) $display("FAIL reset_rd_idx: got %0d want 0", bus.hf_rd_idx_o);
    else pass_cnt++;
    rsn_i = 1'b0;
    tick();
  endtask

  task automatic test_writeback();
    bus.wb_req_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'hCAFE;
    #1;
    total_cnt++;
    if ({bus.wb_gnt_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.stall_o} !==
        {1'b1, 1'b1, 5'd5, 32'hCAFE, 1'b0})
      $display("FAIL wb_passthru: gnt=%b we=%b addr=%0d data=%h stall=%b want 1 1 5 cafe 0",
               bus.wb_gnt_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.stall_o);
    else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    total_cnt++;
    if ({bus.wb_gnt_o, bus.rf_we_o} !== 2'b00)
      $display("FAIL wb_release: gnt=%b we=%b want 0 0", bus.wb_gnt_o, bus.rf_we_o);
    else pass_cnt++;
  endtask

  task automatic test_basic_exception();
    hf_reg[4] = 5'd10; hf_val[4] = 32'h4444;
    hf_reg[3] = 5'd11; hf_val[3] = 32'h3333;
    hf_reg[2] = 5'd12; hf_val[2] = 32'h2222;
    bus.hf_head_i = 3'd2; bus.hf_tail_i = 3'd5;
    bus.exc_i = 1'b1; bus.exc_id_i = 3'd2; bus.exc_cause_i = 4'hB;
    #1;
    total_cnt++;
    if (bus.stall_o !== 1'b0) $display("FAIL basic_capture_nostall: got %b want 0", bus.stall_o);
    else pass_cnt++;
    tick();
    bus.exc_i = 1'b0;
    #1;
    run_recovery();
    total_cnt++;
    if (stall_cyc !== 6) $display("FAIL basic_latency: got %0d want 6", stall_cyc);
    else pass_cnt++;
    total_cnt++;
    if (flush_cyc !== 1) $display("FAIL basic_flush_len: got %0d want 1", flush_cyc);
    else pass_cnt++;
    total_cnt++;
    if (pop_trace !== 32'h0000_0CBA) $display("FAIL basic_pops: got %h want 00000cba", pop_trace);
    else pass_cnt++;
    total_cnt++;
    if ({taken_cyc[3:0], taken_cause} !== {4'd1, 4'hB})
      $display("FAIL basic_taken: count=%0d cause=%h want 1 b", taken_cyc, taken_cause);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr.size() !== 3) $display("FAIL basic_nwrites: got %0d want 3", wr_addr.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      total_cnt++;
      if ({wr_addr[i], wr_data[i]} !== {hf_reg[4-i], hf_val[4-i]})
        $display("FAIL basic_write%0d: got %0d/%h want %0d/%h", i, wr_addr[i], wr_data[i],
                 hf_reg[4-i], hf_val[4-i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (out_vec() !== 52'd0) $display("FAIL basic_back_idle: got %h want 0", out_vec());
    else pass_cnt++;
  endtask

  task automatic test_age_capture();
    hf_reg[5] = 5'd1; hf_val[5] = 32'h55;
    hf_reg[4] = 5'd2; hf_val[4] = 32'h44;
    hf_reg[3] = 5'd3; hf_val[3] = 32'h33;
    bus.hf_head_i = 3'd2; bus.hf_tail_i = 3'd6;
    bus.exc_i = 1'b1; bus.exc_id_i = 3'd4; bus.exc_cause_i = 4'h1;
    tick();
    bus.exc_id_i = 3'd3; bus.exc_cause_i = 4'h2;
    tick();
    bus.exc_id_i = 3'd5; bus.exc_cause_i = 4'h3;
    tick();
    bus.exc_id_i = 3'd3; bus.exc_cause_i = 4'h4;
    tick();
    bus.exc_i = 1'b0;
    #1;
    total_cnt++;
    if ({bus.stall_o, bus.flush_o} !== 2'b10)
      $display("FAIL age_waiting: stall=%b flush=%b want 1 0", bus.stall_o, bus.flush_o);
    else pass_cnt++;
    bus.hf_head_i = 3'd3;
    #1;
    run_recovery();
    total_cnt++;
    if (taken_cause !== 4'h2) $display("FAIL age_cause: got %h want 2", taken_cause);
    else pass_cnt++;
    total_cnt++;
    if (pop_trace !== 32'h0000_0DCB) $display("FAIL age_pops: got %h want 00000dcb", pop_trace);
    else pass_cnt++;
    total_cnt++;
    if (stall_cyc !== 6) $display("FAIL age_latency: got %0d want 6", stall_cyc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    hf_reg[0] = 5'd0; hf_val[0] = 32'h0BAD;
    hf_reg[7] = 5'd7; hf_val[7] = 32'h7777;
    bus.hf_head_i = 3'd6; bus.hf_tail_i = 3'd1;
    bus.exc_i = 1'b1; bus.exc_id_i = 3'd7; bus.exc_cause_i = 4'h5;
    tick();
    bus.exc_i = 1'b0;
    tick();
    total_cnt++;
    if ({bus.stall_o, bus.flush_o} !== 2'b10)
      $display("FAIL wrap_waiting: stall=%b flush=%b want 1 0", bus.stall_o, bus.flush_o);
    else pass_cnt++;
    bus.hf_head_i = 3'd7;
    #1;
    run_recovery();
    total_cnt++;
    if (pop_trace !== 32'h0000_008F) $display("FAIL wrap_pops: got %h want 0000008f", pop_trace);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr.size() !== 1) $display("FAIL wrap_nwrites: got %0d want 1", wr_addr.size());
    else pass_cnt++;
    if (wr_addr.size() > 0) begin
      total_cnt++;
      if ({wr_addr[0], wr_data[0]} !== {5'd7, 32'h7777})
        $display("FAIL wrap_write: got %0d/%h want 7/7777", wr_addr[0], wr_data[0]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({stall_cyc[7:0], bus.hf_tail_i} !== {8'd5, 3'd7})
      $display("FAIL wrap_latency_tail: cycles=%0d tail=%0d want 5 7", stall_cyc, bus.hf_tail_i);
    else pass_cnt++;
  endtask

  task automatic test_wb_during_restore();
    hf_reg[2] = 5'd20; hf_val[2] = 32'h2020;
    hf_reg[1] = 5'd21; hf_val[1] = 32'h2121;
    bus.hf_head_i = 3'd1; bus.hf_tail_i = 3'd3;
    bus.wb_req_i = 1'b1; bus.wb_addr_i = 5'd9; bus.wb_data_i = 32'h99;
    bus.exc_i = 1'b1; bus.exc_id_i = 3'd1; bus.exc_cause_i = 4'h9;
    #1;
    total_cnt++;
    if ({bus.wb_gnt_o, bus.rf_waddr_o} !== {1'b1, 5'd9})
      $display("FAIL wbr_idle_grant: gnt=%b addr=%0d want 1 9", bus.wb_gnt_o, bus.rf_waddr_o);
    else pass_cnt++;
    tick();
    bus.exc_i = 1'b0;
    #1;
    run_recovery();
    total_cnt++;
    if (busy_gnt !== 0) $display("FAIL wbr_no_grant: got %0d grants want 0", busy_gnt);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr.size() !== 2) $display("FAIL wbr_nwrites: got %0d want 2", wr_addr.size());
    else pass_cnt++;
    for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
      total_cnt++;
      if ({wr_addr[i], wr_data[i]} !== {hf_reg[2-i], hf_val[2-i]})
        $display("FAIL wbr_write%0d: got %0d/%h want %0d/%h", i, wr_addr[i], wr_data[i],
                 hf_reg[2-i], hf_val[2-i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({bus.wb_gnt_o, bus.rf_we_o, bus.rf_waddr_o} !== {1'b1, 1'b1, 5'd9})
      $display("FAIL wbr_regrant: gnt=%b we=%b addr=%0d want 1 1 9",
               bus.wb_gnt_o, bus.rf_we_o, bus.rf_waddr_o);
    else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_restore();
    bus.hf_head_i = 3'd0; bus.hf_tail_i = 3'd4;
    bus.exc_i = 1'b1; bus.exc_id_i = 3'd0; bus.exc_cause_i = 4'h7;
    tick();
    bus.exc_i = 1'b0;
    tick(); tick();
    total_cnt++;
    if (bus.recovering_o !== 1'b1) $display("FAIL rst_mid_inwalk: got %b want 1", bus.recovering_o);
    else pass_cnt++;
    rsn_i = 1'b1;
    tick();
    total_cnt++;
    if (out_vec() !== 52'd0) $display("FAIL rst_mid_outputs: got %h want 0", out_vec());
    else pass_cnt++;
    rsn_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.stall_o !== 1'b0) $display("FAIL rst_mid_idle: stall=%b want 0", bus.stall_o);
    else pass_cnt++;
    hf_reg[4] = 5'd4; hf_val[4] = 32'h4040;
    hf_reg[3] = 5'd3; hf_val[3] = 32'h3030;
    bus.hf_head_i = 3'd3; bus.hf_tail_i = 3'd5;
    bus.exc_i = 1'b1; bus.exc_id_i = 3'd3; bus.exc_cause_i = 4'h6;
    tick();
    bus.exc_i = 1'b0;
    #1;
    run_recovery();
    total_cnt++;
    if ({pop_trace, taken_cause} !== {32'h0000_00CB, 4'h6})
      $display("FAIL rst_mid_new_exc: pops=%h cause=%h want 000000cb 6", pop_trace, taken_cause);
    else pass_cnt++;
    total_cnt++;
    if (stall_cyc !== 5) $display("FAIL rst_mid_latency: got %0d want 5", stall_cyc);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < HF_DEPTH; i++) begin
      hf_reg[i] = '0;
      hf_val[i] = '0;
    end
    test_reset();
    test_writeback();
    test_basic_exception();
    test_age_capture();
    test_wrap();
    test_wb_during_restore();
    test_reset_mid_restore();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
